// File: rtl/vx_mem_perf_tracker.sv
// Observe-only memory performance tracker: counts read/write requests,
// outstanding-read latency, dcache bank stalls, and pending-read tracking errors.
`ifndef PERF_CTR_BITS
`define PERF_CTR_BITS 44
`endif

module vx_mem_perf_tracker #(
    parameter int CTR_BITS  = `PERF_CTR_BITS,
    parameter int NUM_BANKS = 4,
    parameter int PEND_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_req_valid,
    input  logic                 mem_req_rw,
    input  logic                 mem_req_ready,
    input  logic                 mem_rsp_valid,
    input  logic                 mem_rsp_ready,
    input  logic [NUM_BANKS-1:0] bank_stall,
    output logic [CTR_BITS-1:0]  mem_reads,
    output logic [CTR_BITS-1:0]  mem_writes,
    output logic [CTR_BITS-1:0]  mem_latency,
    output logic [CTR_BITS-1:0]  dcache_bank_stalls,
    output logic [PEND_BITS-1:0] pending_reads,
    output logic                 track_error
);

    localparam int STALL_W = $clog2(NUM_BANKS + 1);
    localparam logic [PEND_BITS-1:0] PEND_MAX = {PEND_BITS{1'b1}};

    logic                 req_fire;
    logic                 rsp_fire;
    logic                 rd_fire;
    logic                 wr_fire;
    logic [STALL_W-1:0]   stall_cnt;

    logic [CTR_BITS-1:0]  reads_q,   reads_d;
    logic [CTR_BITS-1:0]  writes_q,  writes_d;
    logic [CTR_BITS-1:0]  lat_q,     lat_d;
    logic [CTR_BITS-1:0]  stalls_q,  stalls_d;
    logic [PEND_BITS-1:0] pend_q,    pend_d;
    logic                 err_q,     err_d;

    assign req_fire = mem_req_valid & mem_req_ready;
    assign rsp_fire = mem_rsp_valid & mem_rsp_ready;
    assign rd_fire  = req_fire & ~mem_req_rw;
    assign wr_fire  = req_fire & mem_req_rw;

    always_comb begin
        stall_cnt = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            stall_cnt = stall_cnt + STALL_W'(bank_stall[i]);
        end
    end

    always_comb begin
        reads_d  = reads_q + CTR_BITS'(rd_fire);
        writes_d = writes_q + CTR_BITS'(wr_fire);
        lat_d    = lat_q + CTR_BITS'(pend_q);
        stalls_d = stalls_q + CTR_BITS'(stall_cnt);
        pend_d   = pend_q;
        err_d    = err_q;
        // A read issued and retired in the same cycle nets to zero even at the limits.
        unique case ({rd_fire, rsp_fire})
            2'b10: begin
                if (pend_q == PEND_MAX) begin
                    err_d = 1'b1;
                end else begin
                    pend_d = pend_q + 1'b1;
                end
            end
            2'b01: begin
                if (pend_q == '0) begin
                    err_d = 1'b1;
                end else begin
                    pend_d = pend_q - 1'b1;
                end
            end
            default: pend_d = pend_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reads_q  <= '0;
            writes_q <= '0;
            lat_q    <= '0;
            stalls_q <= '0;
            pend_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            reads_q  <= reads_d;
            writes_q <= writes_d;
            lat_q    <= lat_d;
            stalls_q <= stalls_d;
            pend_q   <= pend_d;
            err_q    <= err_d;
        end
    end

    assign mem_reads          = reads_q;
    assign mem_writes         = writes_q;
    assign mem_latency        = lat_q;
    assign dcache_bank_stalls = stalls_q;
    assign pending_reads      = pend_q;
    assign track_error        = err_q;

endmodule

// File: tb/tb_vx_mem_perf_tracker.sv
// Directed bench with a cycle-level reference model feeding an expectation queue,
// plus fixed-value checks of the scenario end points.
module tb_vx_mem_perf_tracker;

    localparam int CB = 8;
    localparam int NB = 4;
    localparam int PB = 8;

    typedef struct {
        logic [CB-1:0] reads;
        logic [CB-1:0] writes;
        logic [CB-1:0] lat;
        logic [CB-1:0] stalls;
        logic [PB-1:0] pend;
        logic          err;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          mem_req_valid = 1'b0;
    logic          mem_req_rw = 1'b0;
    logic          mem_req_ready = 1'b0;
    logic          mem_rsp_valid = 1'b0;
    logic          mem_rsp_ready = 1'b0;
    logic [NB-1:0] bank_stall = '0;
    logic [CB-1:0] mem_reads;
    logic [CB-1:0] mem_writes;
    logic [CB-1:0] mem_latency;
    logic [CB-1:0] dcache_bank_stalls;
    logic [PB-1:0] pending_reads;
    logic          track_error;

    int   errors = 0;
    int   checks = 0;
    exp_t m;
    exp_t q[$];

    vx_mem_perf_tracker #(.CTR_BITS(CB), .NUM_BANKS(NB), .PEND_BITS(PB)) dut (
        .clk(clk),
        .reset(reset),
        .mem_req_valid(mem_req_valid),
        .mem_req_rw(mem_req_rw),
        .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_ready(mem_rsp_ready),
        .bank_stall(bank_stall),
        .mem_reads(mem_reads),
        .mem_writes(mem_writes),
        .mem_latency(mem_latency),
        .dcache_bank_stalls(dcache_bank_stalls),
        .pending_reads(pending_reads),
        .track_error(track_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle, advance the model, queue its expectation, compare after the edge.
    task automatic cyc(input logic rst, input logic rv, input logic rw, input logic rr,
                       input logic sv, input logic sr, input logic [NB-1:0] st);
        logic rd, wr, rs;
        exp_t e;
        int   pc;
        reset = rst; mem_req_valid = rv; mem_req_rw = rw; mem_req_ready = rr;
        mem_rsp_valid = sv; mem_rsp_ready = sr; bank_stall = st;
        rd = rv & rr & ~rw;
        wr = rv & rr & rw;
        rs = sv & sr;
        pc = 0;
        for (int i = 0; i < NB; i++) pc += int'(st[i]);
        if (rst) begin
            m = '{default: '0};
        end else begin
            m.lat    = m.lat + CB'(m.pend);
            m.reads  = m.reads + CB'(rd);
            m.writes = m.writes + CB'(wr);
            m.stalls = m.stalls + CB'(pc);
            if (rd && !rs) begin
                if (m.pend == '1) m.err = 1'b1;
                else m.pend = m.pend + 1'b1;
            end else if (rs && !rd) begin
                if (m.pend == '0) m.err = 1'b1;
                else m.pend = m.pend - 1'b1;
            end
        end
        e = m;
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("reads", 32'(mem_reads), 32'(e.reads));
        chk("writes", 32'(mem_writes), 32'(e.writes));
        chk("latency", 32'(mem_latency), 32'(e.lat));
        chk("stalls", 32'(dcache_bank_stalls), 32'(e.stalls));
        chk("pending", 32'(pending_reads), 32'(e.pend));
        chk("error", 32'(track_error), 32'(e.err));
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, '0);
    endtask

    task automatic rd_req();
        cyc(0, 1, 0, 1, 0, 0, '0);
    endtask

    task automatic rsp();
        cyc(0, 0, 0, 0, 1, 1, '0);
    endtask

    task automatic rst_cyc();
        cyc(1, 0, 0, 0, 0, 0, '0);
    endtask

    initial begin
        m = '{default: '0};
        rst_cyc();
        rst_cyc();
        chk("rst_reads", 32'(mem_reads), 0);
        chk("rst_err", 32'(track_error), 0);

        // three reads, responses five cycles later
        rd_req(); rd_req(); rd_req();
        chk("peak_pend", 32'(pending_reads), 3);
        idle(); idle();
        rsp(); rsp(); rsp();
        chk("s1_reads", 32'(mem_reads), 3);
        chk("s1_lat", 32'(mem_latency), 15);
        chk("s1_pend", 32'(pending_reads), 0);
        chk("s1_err", 32'(track_error), 0);

        // writes, one without ready, plus rw don't-care while idle
        rst_cyc();
        cyc(0, 1, 1, 1, 0, 0, '0);
        cyc(0, 1, 1, 1, 0, 0, '0);
        cyc(0, 1, 1, 0, 0, 0, '0);
        cyc(0, 0, 1, 1, 0, 0, '0);
        cyc(0, 0, 0, 1, 1, 0, '0);
        chk("s2_writes", 32'(mem_writes), 2);
        chk("s2_reads", 32'(mem_reads), 0);
        chk("s2_lat", 32'(mem_latency), 0);

        // bank stalls
        rst_cyc();
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 0, 4'b1011);
        chk("s3_stalls", 32'(dcache_bank_stalls), 15);
        cyc(0, 0, 0, 0, 0, 0, 4'b1111);
        chk("s3_stalls_b", 32'(dcache_bank_stalls), 19);

        // underflow is sticky until reset
        rst_cyc();
        rsp();
        chk("s4_pend", 32'(pending_reads), 0);
        chk("s4_err", 32'(track_error), 1);
        idle(); rd_req(); rsp(); idle();
        chk("s4_sticky", 32'(track_error), 1);
        rst_cyc();
        chk("s4_clr", 32'(track_error), 0);
        cyc(0, 1, 0, 1, 1, 1, '0);
        chk("s4_sim_pend", 32'(pending_reads), 0);
        chk("s4_sim_err", 32'(track_error), 0);

        // write counter wrap
        rst_cyc();
        for (int i = 0; i < 255; i++) cyc(0, 1, 1, 1, 0, 0, '0);
        chk("s5_w255", 32'(mem_writes), 255);
        cyc(0, 1, 1, 1, 0, 0, '0);
        chk("s5_wrap", 32'(mem_writes), 0);
        chk("s5_err", 32'(track_error), 0);

        // pending saturation at maximum
        rst_cyc();
        for (int i = 0; i < 255; i++) rd_req();
        chk("s6_max", 32'(pending_reads), 255);
        chk("s6_err0", 32'(track_error), 0);
        cyc(0, 1, 0, 1, 1, 1, '0);
        chk("s6_sim_err", 32'(track_error), 0);
        rd_req();
        chk("s6_hold", 32'(pending_reads), 255);
        chk("s6_err1", 32'(track_error), 1);

        // reset with reads outstanding and a same-cycle read fire
        rst_cyc();
        rd_req(); rd_req();
        cyc(1, 1, 0, 1, 0, 0, 4'b1111);
        chk("s7_reads", 32'(mem_reads), 0);
        chk("s7_pend", 32'(pending_reads), 0);
        chk("s7_lat", 32'(mem_latency), 0);
        chk("s7_stalls", 32'(dcache_bank_stalls), 0);
        rsp();
        chk("s7_orphan_err", 32'(track_error), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vx_mem_perf_tracker.md
VX_MEM_PERF_TRACKER -- requirements
Module: VX_mem_perf_tracker

Interface
REQ-001 SHALL have parameter CTR_BITS, default `PERF_CTR_BITS, width of every event counter.
REQ-002 SHALL have parameter NUM_BANKS, default 4, number of dcache bank-stall event lanes.
REQ-003 SHALL have parameter PEND_BITS, default 8, width of outstanding-read counter.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port mem_req_valid  input  1  memory request valid.
REQ-007 SHALL have port mem_req_rw  input  1  request type: 1 = write, 0 = read.
REQ-008 SHALL have port mem_req_ready  input  1  memory request ready.
REQ-009 SHALL have port mem_rsp_valid  input  1  memory read response valid.
REQ-010 SHALL have port mem_rsp_ready  input  1  memory read response ready.
REQ-011 SHALL have port bank_stall  input  NUM_BANKS  per-bank stall pulse, one bit per bank.
REQ-012 SHALL have port mem_reads  output  CTR_BITS  count of accepted read requests.
REQ-013 SHALL have port mem_writes  output  CTR_BITS  count of accepted write requests.
REQ-014 SHALL have port mem_latency  output  CTR_BITS  accumulated read cycles outstanding.
REQ-015 SHALL have port dcache_bank_stalls  output  CTR_BITS  accumulated bank-stall events.
REQ-016 SHALL have port pending_reads  output  PEND_BITS  current outstanding read count.
REQ-017 SHALL have port track_error  output  1  sticky flag for pending underflow or overflow.

Function
REQ-018 SHALL define req_fire = mem_req_valid & mem_req_ready and rsp_fire = mem_rsp_valid & mem_rsp_ready, sampled each cycle.
REQ-019 SHALL increment mem_reads by 1 on the edge after a cycle with req_fire & ~mem_req_rw.
REQ-020 SHALL increment mem_writes by 1 on the edge after a cycle with req_fire & mem_req_rw.
REQ-021 SHALL update pending_reads each cycle by +1 on read req_fire and -1 on rsp_fire; both in the same cycle give no net change.
REQ-022 SHALL add the current registered pending_reads value (pre-update), zero-extended to CTR_BITS, to mem_latency every cycle.
REQ-023 SHALL add popcount(bank_stall) (0..NUM_BANKS) to dcache_bank_stalls every cycle.
REQ-024 SHALL make all counter outputs direct register outputs, with one-cycle latency from event to visible count.
REQ-025 SHALL wrap mem_reads, mem_writes, mem_latency and dcache_bank_stalls modulo 2^CTR_BITS without flagging.
REQ-026 SHALL hold pending_reads at 0 on rsp_fire without a simultaneous read req_fire when pending_reads = 0, and set track_error.
REQ-027 SHALL hold pending_reads at 2^PEND_BITS-1 on read req_fire without a simultaneous rsp_fire when at that maximum, and set track_error.
REQ-028 SHALL apply simultaneous read req_fire and rsp_fire at pending_reads = 0 or at maximum as net zero, with no error.
REQ-029 SHALL keep track_error set until reset once it is set.
REQ-030 SHALL ignore write requests for pending_reads and mem_latency.
REQ-031 SHALL treat mem_req_rw as don't-care when req_fire is 0.
REQ-032 SHALL never stall or back-pressure any handshake; the block is observe-only and has no ready outputs.

Reset
REQ-033 SHALL clear mem_reads, mem_writes, mem_latency, dcache_bank_stalls, pending_reads and track_error to 0 on the edge where reset = 1.
REQ-034 SHALL give reset priority over any same-cycle event; events during a reset cycle are discarded.
REQ-035 SHALL discard outstanding reads on reset mid-operation; later responses to them underflow per REQ-026.

Verification
REQ-036 SHALL cover: 3 read fires at cycles 0,1,2, responses at cycles 5,6,7 -> mem_reads = 3, pending peaks at 3, final mem_latency = 15, pending = 0.
REQ-037 SHALL cover: 2 write fires and 1 valid-without-ready write -> mem_writes = 2, mem_reads = 0, mem_latency = 0.
REQ-038 SHALL cover: bank_stall = 4'b1011 for 5 cycles -> dcache_bank_stalls = 15.
REQ-039 SHALL cover: rsp_fire at pending = 0 -> pending stays 0 and track_error = 1 until reset; simultaneous read req_fire + rsp_fire at pending = 0 -> no error.
REQ-040 SHALL cover: CTR_BITS = 8, mem_writes preloaded to 255 via 255 write fires, then one more -> mem_writes = 0 with track_error unchanged.
REQ-041 SHALL cover: reset asserted with pending = 2 and a same-cycle read fire -> all outputs 0 on the next cycle.
